// File: rtl/stdcore_2prf_fifo_pkg.sv
// Width and capacity helpers shared by the 2-port register-file FIFO.
`timescale 1ns/1ps
package stdcore_2prf_fifo_pkg;

  // RAM entries plus the head and skid output registers.
  function automatic int fifo_cap(input int depth);
    return depth + 2;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/stdcore_2prf_fifo_if.sv
// Handshake bundle between a producer/consumer pair and the FIFO.
`timescale 1ns/1ps
interface stdcore_2prf_fifo_if #(
  parameter int DW = 8,
  parameter int LW = 8
);
  logic          clr;
  logic          wr_vld;
  logic          wr_rdy;
  logic [DW-1:0] wr_data;
  logic          rd_vld;
  logic          rd_rdy;
  logic [DW-1:0] rd_data;
  logic [LW-1:0] level;
  logic          afull;
  logic          aempty;
  logic          err;

  modport master (
    output clr, wr_vld, wr_data, rd_rdy,
    input  wr_rdy, rd_vld, rd_data, level, afull, aempty, err
  );

  modport slave (
    input  clr, wr_vld, wr_data, rd_rdy,
    output wr_rdy, rd_vld, rd_data, level, afull, aempty, err
  );
endinterface

// File: rtl/stdcore_2prf.sv
// Two-port register-file macro: active-low enables, registered read data.
`timescale 1ns/1ps
module stdcore_2prf #(
  parameter int DW    = 8,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          wclk,
  input  logic          we_n,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rclk,
  input  logic          re_n,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge wclk)
    if (!we_n) mem[waddr] <= wdata;

  // rdata holds its last value when no read is issued.
  always_ff @(posedge rclk)
    if (!re_n) rdata <= mem[raddr];
endmodule

// File: rtl/stdcore_2prf_fifo.sv
// First-word-fall-through FIFO on the 2-port RF macro; a head/skid pair
// hides the one-cycle read latency so the consumer sees a registered head.
`timescale 1ns/1ps
module stdcore_2prf_fifo
  import stdcore_2prf_fifo_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEPTH     = 128,
  parameter int AW        = addr_w(DEPTH),
  parameter int LW        = level_w(DEPTH),
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  stdcore_2prf_fifo_if.slave bus
);
  localparam int            CW   = cnt_w(DEPTH);
  localparam logic [LW-1:0] CAP  = LW'(fifo_cap(DEPTH));
  localparam logic [LW-1:0] AF   = LW'(AFULL_TH);
  localparam logic [LW-1:0] AE   = LW'(AEMPTY_TH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] ram_cnt;
  logic          rd_inflight;
  logic          head_vld, skid_vld;
  logic [DW-1:0] head_q, skid_q, ram_rdata;
  logic [LW-1:0] level_q;
  logic          wr_rdy_q, afull_q, aempty_q, err_q;

  logic          push, pop, byp, ram_wr, ram_rd, in_vld;
  logic [1:0]    occ_after;
  logic [DW-1:0] in_data;
  logic [LW-1:0] level_nxt;

  always_comb begin
    push      = bus.wr_vld & wr_rdy_q & ~bus.clr;
    pop       = head_vld & bus.rd_rdy & ~bus.clr;
    occ_after = {1'b0, head_vld} + {1'b0, skid_vld} - {1'b0, pop};
    // Bypass only when nothing older is in RAM or on its way out of it.
    byp       = push & (ram_cnt == '0) & ~rd_inflight & (occ_after != 2'd2);
    ram_wr    = push & ~byp;
    // Issue only if the word can land next cycle without a pop to make room.
    ram_rd    = ~bus.clr & (ram_cnt != '0) & ((occ_after + {1'b0, rd_inflight}) <= 2'd1);
    in_vld    = (rd_inflight & ~bus.clr) | byp;
    in_data   = rd_inflight ? ram_rdata : bus.wr_data;
    level_nxt = bus.clr ? '0 : level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.clr) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (ram_wr) wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
      if (ram_rd) rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
      ram_cnt     <= ram_cnt + CW'(ram_wr) - CW'(ram_rd);
      rd_inflight <= ram_rd;
    end
  end

  // Head takes new data when empty or popped; otherwise the skid catches it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
    end else if (bus.clr) begin
      head_vld <= 1'b0;
      skid_vld <= 1'b0;
    end else if (pop && skid_vld) begin
      head_q   <= skid_q;
      skid_vld <= in_vld;
      if (in_vld) skid_q <= in_data;
    end else if (pop || !head_vld) begin
      head_vld <= in_vld;
      if (in_vld) head_q <= in_data;
    end else if (in_vld) begin
      skid_vld <= 1'b1;
      skid_q   <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      wr_rdy_q <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      level_q  <= level_nxt;
      wr_rdy_q <= level_nxt < CAP;
      afull_q  <= level_nxt >= AF;
      aempty_q <= level_nxt <= AE;
      err_q    <= ~bus.clr & (err_q | (bus.wr_vld & ~wr_rdy_q));
    end
  end

  stdcore_2prf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .wclk  (clk),
    .we_n  (~ram_wr),
    .waddr (wptr),
    .wdata (bus.wr_data),
    .rclk  (clk),
    .re_n  (~ram_rd),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  assign bus.wr_rdy  = wr_rdy_q;
  assign bus.rd_vld  = head_vld;
  assign bus.rd_data = head_q;
  assign bus.level   = level_q;
  assign bus.afull   = afull_q;
  assign bus.aempty  = aempty_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_stdcore_2prf_fifo.sv
// Bench for stdcore_2prf_fifo: DEPTH=8 and DEPTH=5 instances share stimulus,
// each checked against a queue model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_stdcore_2prf_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, wr_vld = 1'b0, rd_rdy = 1'b0;
  logic [7:0] wr_data = 8'h00;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int DEP  = (g == 0) ? 8 : 5;
    localparam int CAPM = DEP + 2;

    stdcore_2prf_fifo_if #(.DW(8), .LW($clog2(DEP + 3))) ifc ();
    stdcore_2prf_fifo #(.DW(8), .DEPTH(DEP)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    assign ifc.clr     = clr;
    assign ifc.wr_vld  = wr_vld;
    assign ifc.wr_data = wr_data;
    assign ifc.rd_rdy  = rd_rdy;

    logic [7:0] q[$];
    bit         rdy_m, err_m;

    // Reference: a plain queue, updated with the handshakes seen at each edge.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        rdy_m = 1'b0;
        err_m = 1'b0;
      end else begin
        if (!dut.u_ram.we_n && !dut.u_ram.re_n)
          chk($sformatf("i%0d ram addr clash", g), 32'(dut.u_ram.waddr == dut.u_ram.raddr), 32'd0);
        if (clr) begin
          q.delete();
          err_m = 1'b0;
        end else begin
          if (wr_vld && !rdy_m) err_m = 1'b1;
          if (ifc.rd_vld && rd_rdy && q.size() > 0) void'(q.pop_front());
          if (wr_vld && rdy_m) q.push_back(wr_data);
        end
        rdy_m = (q.size() < CAPM);
      end
    end

    always @(negedge clk) begin
      if (rst_n) begin
        chk($sformatf("i%0d level", g), 32'(ifc.level), q.size());
        chk($sformatf("i%0d level<=cap", g), 32'(ifc.level <= CAPM), 32'd1);
        chk($sformatf("i%0d wr_rdy", g), 32'(ifc.wr_rdy), 32'(rdy_m));
        chk($sformatf("i%0d afull", g), 32'(ifc.afull), 32'(q.size() >= DEP - 2));
        chk($sformatf("i%0d aempty", g), 32'(ifc.aempty), 32'(q.size() <= 2));
        chk($sformatf("i%0d err", g), 32'(ifc.err), 32'(err_m));
        if (ifc.rd_vld) begin
          chk($sformatf("i%0d rd_vld nonempty", g), 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) chk($sformatf("i%0d rd_data", g), 32'(ifc.rd_data), 32'(q[0]));
        end
      end
    end
  end

  task automatic push(input logic [7:0] d);
    wr_vld  = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_vld  = 1'b0;
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!gi[0].ifc.wr_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_rdy wait", 32'(gi[0].ifc.wr_rdy), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " wr_rdy"}, 32'(gi[0].ifc.wr_rdy), 32'd0);
    chk({tag, " rd_vld"}, 32'(gi[0].ifc.rd_vld), 32'd0);
    chk({tag, " rd_data"}, 32'(gi[0].ifc.rd_data), 32'd0);
    chk({tag, " level"}, 32'(gi[0].ifc.level), 32'd0);
    chk({tag, " afull"}, 32'(gi[0].ifc.afull), 32'd0);
    chk({tag, " aempty"}, 32'(gi[0].ifc.aempty), 32'd1);
    chk({tag, " err"}, 32'(gi[0].ifc.err), 32'd0);
    chk({tag, " i1 level"}, 32'(gi[1].ifc.level), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Bypass into an empty FIFO is visible one edge later.
    wait_rdy();
    push(8'hA5);
    chk("byp rd_vld", 32'(gi[0].ifc.rd_vld), 32'd1);
    chk("byp rd_data", 32'(gi[0].ifc.rd_data), 32'hA5);
    chk("byp level", 32'(gi[0].ifc.level), 32'd1);
    chk("byp aempty", 32'(gi[0].ifc.aempty), 32'd1);
    rd_rdy = 1'b1; @(negedge clk); rd_rdy = 1'b0;

    // Fill to CAP=10, then drain back-to-back.
    for (int i = 1; i <= 10; i++) push(8'(i));
    chk("fill wr_rdy", 32'(gi[0].ifc.wr_rdy), 32'd0);
    chk("fill level", 32'(gi[0].ifc.level), 32'd10);
    chk("fill afull", 32'(gi[0].ifc.afull), 32'd1);
    rd_rdy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      chk("drain rd_vld", 32'(gi[0].ifc.rd_vld), 32'd1);
      chk("drain rd_data", 32'(gi[0].ifc.rd_data), 32'(i));
      @(negedge clk);
    end
    rd_rdy = 1'b0;
    chk("drain empty rd_vld", 32'(gi[0].ifc.rd_vld), 32'd0);
    chk("drain empty level", 32'(gi[0].ifc.level), 32'd0);
    chk("i1 overflow err", 32'(gi[1].ifc.err), 32'd1);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("i1 clr err", 32'(gi[1].ifc.err), 32'd0);

    // Overflow: writes into a full FIFO are dropped and err sticks.
    for (int i = 1; i <= 10; i++) push(8'(8'h20 + i));
    wr_vld = 1'b1; wr_data = 8'hFF;
    repeat (2) @(negedge clk);
    wr_vld = 1'b0;
    chk("ovf err", 32'(gi[0].ifc.err), 32'd1);
    chk("ovf level", 32'(gi[0].ifc.level), 32'd10);
    repeat (3) @(negedge clk);
    chk("ovf err sticky", 32'(gi[0].ifc.err), 32'd1);
    rd_rdy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      chk("ovf data", 32'(gi[0].ifc.rd_data), 32'(8'h20 + i));
      @(negedge clk);
    end
    rd_rdy = 1'b0;
    chk("ovf err after drain", 32'(gi[0].ifc.err), 32'd1);

    // Clear with level=6 and a RAM read in flight.
    for (int i = 1; i <= 6; i++) push(8'(8'h30 + i));
    wr_vld = 1'b1; wr_data = 8'h37; rd_rdy = 1'b1;
    @(negedge clk);
    wr_vld = 1'b0; rd_rdy = 1'b0;
    chk("mid level", 32'(gi[0].ifc.level), 32'd6);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr level", 32'(gi[0].ifc.level), 32'd0);
    chk("clr rd_vld", 32'(gi[0].ifc.rd_vld), 32'd0);
    chk("clr err", 32'(gi[0].ifc.err), 32'd0);
    chk("clr wr_rdy", 32'(gi[0].ifc.wr_rdy), 32'd1);
    push(8'h11);
    chk("post clr rd_vld", 32'(gi[0].ifc.rd_vld), 32'd1);
    chk("post clr rd_data", 32'(gi[0].ifc.rd_data), 32'h11);
    rd_rdy = 1'b1; @(negedge clk); rd_rdy = 1'b0;
    chk("post clr level", 32'(gi[0].ifc.level), 32'd0);

    // Streaming with random back-pressure and an async reset mid-run.
    wr_vld = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      wr_data = 8'(c * 7 + 3);
      rd_rdy  = ($urandom_range(0, 3) != 0);
      if (c == 500) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        wr_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr_vld = 1'b1;
      end
      @(negedge clk);
    end
    wr_vld = 1'b0;
    rd_rdy = 1'b1;
    repeat (15) @(negedge clk);
    rd_rdy = 1'b0;
    chk("final level i0", 32'(gi[0].ifc.level), 32'd0);
    chk("final level i1", 32'(gi[1].ifc.level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
